// File: rtl/bcd_left_pack_if.sv
// Handshake and result bus between the binary source, the BCD packer and the
// downstream digit-scan stage.
interface bcd_left_pack_if;
  logic        start;
  logic [26:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic [3:0]  num;
  logic        ovf;

  modport master (output start, bin, input busy, done, bcd_out, num, ovf);
  modport slave  (input start, bin, output busy, done, bcd_out, num, ovf);
endinterface

// File: rtl/bcd_left_pack.sv
// 27-bit binary to 8-digit packed BCD (shift-add-3), then left-justified so the
// most significant non-zero digit lands in [31:28]; num reports digits-1.

// One BCD digit lane of the double-dabble correction.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_left_pack (
  input  logic            clk,
  input  logic            rst,
  bcd_left_pack_if.slave  bus
);
  localparam int          NUM_LANES = 8;
  localparam int          VEC_W     = 4;
  localparam int          BIN_W     = 27;
  localparam logic [4:0]  LAST_ITER = 5'd26;
  localparam logic [26:0] OVF_LIM   = 27'd100000000;

  typedef enum logic [1:0] {IDLE, CONV, PACK} state_t;

  state_t                              state, state_nx;
  logic [BIN_W-1:0]                    binreg;
  logic [NUM_LANES-1:0][VEC_W-1:0]     work, work_adj;
  logic [4:0]                          iter;
  logic [2:0]                          lz;
  logic                                ovf_pend;

  logic [31:0]                         bcd_q;
  logic [3:0]                          num_q;
  logic                                ovf_q, done_q;

  logic                                accept, conv_step, pk_shift, pk_load, busy_c;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      bcd_add3 u_lane (.d(work[g]), .q(work_adj[g]));
    end
  endgenerate

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start)         state_nx = CONV;
      CONV:    if (iter == LAST_ITER) state_nx = PACK;
      PACK:    if (pk_load)           state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // control strobes; an overflow skips justification and loads at once
  always_comb begin
    accept    = (state == IDLE) && bus.start;
    conv_step = (state == CONV);
    pk_shift  = (state == PACK) && !ovf_pend &&
                (work[NUM_LANES-1] == 4'h0) && (lz != 3'd7);
    pk_load   = (state == PACK) && !pk_shift;
    busy_c    = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      binreg   <= '0;
      work     <= '0;
      iter     <= '0;
      lz       <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      num_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        binreg   <= bus.bin;
        work     <= '0;
        iter     <= '0;
        lz       <= '0;
        ovf_pend <= (bus.bin >= OVF_LIM);
      end
      if (conv_step) begin
        {work, binreg} <= {work_adj, binreg} << 1;
        iter           <= iter + 5'd1;
      end
      if (pk_shift) begin
        work <= {work[NUM_LANES-2:0], 4'h0};
        lz   <= lz + 3'd1;
      end
      if (pk_load) begin
        done_q <= 1'b1;
        if (ovf_pend) begin
          bcd_q <= 32'h9999_9999;
          num_q <= 4'd7;
          ovf_q <= 1'b1;
        end else begin
          bcd_q <= work;
          num_q <= 4'd7 - {1'b0, lz};
          ovf_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.num     = num_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: doc/bcd_left_pack.md
BCD_LEFT_PACK -- requirements
Module: bcd_left_pack

Interface
REQ-001 The block SHALL have no parameters; the widths below are fixed.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to convert bin; sampled only in IDLE.
REQ-006 bin  input  27  unsigned binary value; captured on the accepted start edge.
REQ-007 busy  output  1  high while converting (states CONV and PACK).
REQ-008 done  output  1  one-cycle pulse when new results are loaded.
REQ-009 bcd_out  output  32  left-justified packed BCD, 8 digits; most significant digit in [31:28]; feeds the digit-scan stage input.
REQ-010 num  output  4  significant digit count minus 1 (0..7); feeds the digit-scan stage count input.
REQ-011 ovf  output  1  high when the last captured bin was >= 100,000,000.

Function
REQ-012 The state machine SHALL have states IDLE, CONV and PACK.
REQ-013 IDLE: on start=1, capture bin into a 27-bit shift register, clear the 32-bit BCD work register, the 5-bit iteration counter and the 3-bit shift count lz, latch ovf_pend=(bin>=100000000), and go to CONV; otherwise hold.
REQ-014 CONV, each edge: for each of the 8 work nibbles, add 3 if the nibble is >=5; then shift {work, binreg} left by 1; increment the iteration counter.
REQ-015 CONV SHALL perform exactly 27 iterations (edges E1..E27, where E0 is the start edge) and go to PACK on E27.
REQ-016 PACK, each edge: if ovf_pend=0, work[31:28]==0 and lz<7, shift work left by 4 (zero fill) and increment lz; otherwise perform the load step in REQ-017.
REQ-017 Load step: bcd_out<=work, num<=7-lz, ovf<=0, done<=1, state<=IDLE.
REQ-018 If ovf_pend=1, PACK SHALL load on its first edge (E28) with bcd_out=32'h99999999, num=7 and ovf=1, and SHALL not shift.
REQ-019 Latency: done SHALL be high in the cycle after edge E28+lz; the minimum is 28 cycles and the maximum is 35 cycles (bin=0).
REQ-020 For bin=0, the result SHALL be bcd_out=0 and num=0 (one displayed digit "0").
REQ-021 done SHALL be high for exactly one cycle.
REQ-022 busy SHALL be low in the cycle done is high.
REQ-023 start while busy=1 SHALL be ignored; changes to bin after capture SHALL have no effect.
REQ-024 start asserted in the cycle done is high SHALL be accepted, because the state is already IDLE.
REQ-025 bcd_out, num and ovf SHALL hold their values until the next load step; an accepted start SHALL not clear them.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from an input to an output.

Reset
REQ-027 When rst=1 at a clock edge: state<=IDLE; busy=0, done=0, bcd_out=0, num=0, ovf=0; internal registers cleared.
REQ-028 rst SHALL take priority over start and over any in-progress conversion.
REQ-029 Reset mid-CONV or mid-PACK SHALL abort the conversion with no done pulse.
REQ-030 After reset, the downstream scan stage SHALL display a single "0".

Verification
REQ-031 bin=12345678, start pulse -> done after E28; bcd_out=32'h12345678, num=7, ovf=0; busy high for E1..E28 only.
REQ-032 bin=305 -> done after E33; bcd_out=32'h30500000, num=2, ovf=0.
REQ-033 bin=0 -> done after E35; bcd_out=32'h00000000, num=0; bin=7 -> bcd_out=32'h70000000, num=0, done after E35.
REQ-034 bin=99999999 -> bcd_out=32'h99999999, num=7, ovf=0; bin=100000000 -> bcd_out=32'h99999999, num=7, ovf=1, done after E28.
REQ-035 Start with bin=42, then start with bin=9 at E5 -> the second start is ignored; result bcd_out=32'h42000000, num=1; start in the done cycle with bin=9 -> accepted, next result bcd_out=32'h90000000, num=0.
REQ-036 rst at E10 of a conversion -> from the next cycle busy=0, done=0, bcd_out=0, num=0, ovf=0; no done pulse is observed afterward until a new start.
